uart_echo: RTL and testbench

- Full-duplex 8N1 UART with serial loopback: every byte received on rx is retransmitted unchanged on tx.
- Runs from a 50 MHz system clock at 19200 baud; the baud divisor is set by parameter.
- Top-level serial interface block for the board's RS-232 link; it has no parallel host interface.

---
 rtl/uart_echo.sv | 181 ++++++++++++++++++
 tb/tb_uart_echo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo.sv
`timescale 1ns/1ps
// uart_echo: 8N1 UART loopback. Bytes arriving on rx are caught in a
// one-byte holding buffer and sent back out on tx. Receiver and
// transmitter run independently; the newest received byte always wins.
module uart_echo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 19200,
  parameter int DIV      = CLK_FREQ / BAUD,
  parameter int HALF     = DIV / 2
) (
  input  logic clk,
  input  logic res,
  input  logic rx,
  output logic tx
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic            rx_p0, rx_p1;
  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_data;
  logic            rx_valid;

  logic [7:0]      hold;
  logic            full;
  logic            tx_load;

  tx_state_t       tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift;

  // Stage p0/p1: two-flop synchronizer, preset to the idle-high line level
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // Receiver FSM: centre-samples each bit, pulses rx_valid on a good stop bit
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_p1) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            // A start bit that is gone by its centre was only a glitch
            rx_state <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt  <= '0;
            rx_data <= {rx_p1, rx_data[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt <= '0;
            if (rx_p1) begin
              rx_valid <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_WAIT;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          rx_cnt <= '0;
          if (rx_p1) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign tx_load = (tx_state == TX_IDLE) && full;

  // Holding buffer: a fresh byte beats the transmitter's clear so none is lost
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hold <= '0;
      full <= 1'b0;
    end else if (rx_valid) begin
      hold <= rx_data;
      full <= 1'b1;
    end else if (tx_load) begin
      full <= 1'b0;
    end
  end

  // Transmitter FSM: tx is driven straight from a flop so it never glitches
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          tx     <= 1'b1;
          if (full) begin
            tx_shift <= hold;
            tx       <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo.sv
`timescale 1ns/1ps
// tb_uart_echo: directed frames on rx, tx decoded bit by bit and compared
// against hand-computed bytes. A fast baud rate (DIV = 64) keeps runs short.
module tb_uart_echo;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 781250;
  localparam int DIV      = CLK_FREQ / BAUD;   // 64 clocks per bit
  localparam int HALF     = DIV / 2;           // 32
  // Stop-bit start to tx fall: 2 sync flops + 1 idle detect + HALF to the
  // start centre + 9*DIV of bits (cancels against the 9 driven bits)
  // + rx_valid->full + full->tx load = HALF + 5.
  localparam int LAT      = HALF + 5;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic rx  = 1'b1;
  logic tx;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int stop_cyc    = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_echo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk),
    .res(res),
    .rx (rx),
    .tx (tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    @(posedge clk);
    #1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    stop_cyc = cyc;
    send_bit(stop_v);
  endtask

  task automatic watch_quiet(input int ncyc, output int lows);
    lows = 0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lows++;
    end
  endtask

  task automatic wait_tx_low(input string tag, input int budget, output bit ok);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (tx === 1'b0);
    if (!ok) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic get_tx_byte(input string tag, input int budget,
                             output logic [7:0] b, output int fall_cyc);
    bit ok;
    b        = '0;
    fall_cyc = -1;
    wait_tx_low(tag, budget, ok);
    if (!ok) return;
    fall_cyc = cyc;
    repeat (HALF) @(posedge clk);
    #1;
    chk({tag, "_start"}, 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk);
      #1;
      b[i] = tx;
    end
    repeat (DIV) @(posedge clk);
    #1;
    chk({tag, "_stop"}, 32'(tx), 32'd1);
  endtask

  initial begin
    logic [7:0] b0, b1;
    int         f0, f1, lows;
    bit         ok;

    // Reset: 100 ns low, then 12 idle bit times
    #100;
    chk("reset_tx", 32'(tx), 32'd1);
    @(posedge clk);
    #1;
    res = 1'b1;
    watch_quiet(12 * DIV, lows);
    chk("idle_quiet", 32'(lows), 32'd0);

    // Single byte 0xAA with latency check
    fork
      send_byte(8'hAA, 1'b1);
      get_tx_byte("aa", 12 * DIV, b0, f0);
    join
    chk("aa_data", 32'(b0), 32'hAA);
    chk("aa_latency", 32'(f0 - stop_cyc), 32'(LAT));

    // Back-to-back 0xAA then 0xA8
    fork
      begin
        send_byte(8'hAA, 1'b1);
        send_bit(1'b1);
        send_byte(8'hA8, 1'b1);
      end
      begin
        get_tx_byte("b2b_first", 12 * DIV, b0, f0);
        get_tx_byte("b2b_second", 14 * DIV, b1, f1);
      end
    join
    chk("b2b_first_data", 32'(b0), 32'hAA);
    chk("b2b_second_data", 32'(b1), 32'hA8);

    // Glitch rejection: 200 ns low pulse
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rx = 1'b1;
    watch_quiet(12 * DIV, lows);
    chk("glitch_quiet", 32'(lows), 32'd0);

    // Framing error: stop bit 0 must not echo, then 0x55 echoes
    fork
      begin
        send_byte(8'h3C, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
      end
      watch_quiet(13 * DIV, lows);
    join
    chk("frame_err_quiet", 32'(lows), 32'd0);
    fork
      send_byte(8'h55, 1'b1);
      get_tx_byte("recover", 12 * DIV, b0, f0);
    join
    chk("recover_data", 32'(b0), 32'h55);

    // Reset during tx data bit 3 of the 0xC3 echo (bit 3 is 0)
    fork
      send_byte(8'hC3, 1'b1);
      begin
        wait_tx_low("mid", 12 * DIV, ok);
        if (ok) begin
          repeat (HALF + 4 * DIV) @(posedge clk);
          #1;
          chk("mid_bit3", 32'(tx), 32'd0);
          res = 1'b0;
          #1;
          chk("mid_reset_tx", 32'(tx), 32'd1);
          repeat (5) @(posedge clk);
          #1;
          res = 1'b1;
        end
      end
    join
    watch_quiet(12 * DIV, lows);
    chk("mid_after_quiet", 32'(lows), 32'd0);
    fork
      send_byte(8'h5A, 1'b1);
      get_tx_byte("post_reset", 12 * DIV, b0, f0);
    join
    chk("post_reset_data", 32'(b0), 32'h5A);

    // Reset while a 0xFF frame is half received: nothing may be echoed
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (5 * DIV) @(posedge clk);
        #1;
        res = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        res = 1'b1;
      end
    join
    watch_quiet(4 * DIV, lows);
    chk("partial_quiet", 32'(lows), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
